// File: rtl/ahbl_dma_master_pkg.sv
// Shared definitions for the AHB-Lite word-copy DMA initiator:
// bus encodings, controller state enumeration and an address helper.
package ahbl_dma_master_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] WORD_BYTES    = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_FIN
    } state_t;

    // Drop the byte offset so every access is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ahbl_dma_master_if.sv
// AHB-Lite initiator-side signal bundle. The master drives the address and
// control phase plus write data; the slave side returns HREADY/HRDATA.
interface ahbl_dma_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA
    );

endinterface

// File: rtl/ahbl_dma_master.sv
// Single-channel AHB-Lite DMA initiator. Copies len_words 32-bit words from
// src_addr to dst_addr, one read then one write per word, with no overlap
// between transfers. All bus outputs come from registered state only.
module ahbl_dma_master
    import ahbl_dma_master_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len_words,
    output logic                 busy,
    output logic                 done,
    ahbl_dma_master_if.master    bus
);

    state_t             state, state_nxt;
    logic [31:0]        src_q;
    logic [31:0]        dst_q;
    logic [31:0]        buf_q;
    logic [LEN_W-1:0]   count_q;

    // State register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignment so every register
            // samples pre-edge values, independent of block ordering.
            state <= state_nxt;
        end
    end

    // Next-state decode; each bus phase advances only when HREADY is high.
    always_comb begin
        // NOTE: defaulting before the case gives every path a value, so no latch.
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = (len_words == '0) ? ST_FIN : ST_RD_ADDR;
            ST_RD_ADDR: if (bus.HREADY) state_nxt = ST_RD_DATA;
            ST_RD_DATA: if (bus.HREADY) state_nxt = ST_WR_ADDR;
            ST_WR_ADDR: if (bus.HREADY) state_nxt = ST_WR_DATA;
            ST_WR_DATA: if (bus.HREADY) state_nxt = (count_q == LEN_W'(1)) ? ST_FIN : ST_RD_ADDR;
            ST_FIN:     state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch the job in IDLE, capture read data, step pointers per word.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            src_q   <= '0;
            dst_q   <= '0;
            buf_q   <= '0;
            count_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        src_q   <= word_align(src_addr);
                        dst_q   <= word_align(dst_addr);
                        count_q <= len_words;
                    end
                end
                ST_RD_DATA: begin
                    if (bus.HREADY) buf_q <= bus.HRDATA;
                end
                ST_WR_DATA: begin
                    if (bus.HREADY) begin
                        // Plain 32-bit add wraps past 0xFFFF_FFFC to zero.
                        src_q   <= src_q + WORD_BYTES;
                        dst_q   <= dst_q + WORD_BYTES;
                        count_q <= count_q - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Bus outputs decoded from state and registers; stable across wait states
    // because nothing they depend on moves while HREADY is low.
    always_comb begin
        bus.HADDR  = '0;
        bus.HTRANS = HTRANS_IDLE;
        bus.HWRITE = 1'b0;
        case (state)
            ST_RD_ADDR: begin
                bus.HADDR  = src_q;
                bus.HTRANS = HTRANS_NONSEQ;
            end
            ST_RD_DATA: begin
                bus.HADDR  = src_q;
            end
            ST_WR_ADDR: begin
                bus.HADDR  = dst_q;
                bus.HTRANS = HTRANS_NONSEQ;
                bus.HWRITE = 1'b1;
            end
            ST_WR_DATA: begin
                bus.HADDR  = dst_q;
                bus.HWRITE = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.HSIZE  = HSIZE_WORD;
    assign bus.HWDATA = buf_q;
    assign busy       = (state != ST_IDLE);
    assign done       = (state == ST_FIN);

endmodule

// File: tb/tb_ahbl_dma_master.sv
// Bench for ahbl_dma_master: a behavioural copy model (expected read/write
// streams and completion cycle) plus an AHB-Lite responder with optional
// data-phase wait states, checked every cycle on the falling clock edge.
module tb_ahbl_dma_master;
    import ahbl_dma_master_pkg::*;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy;
    logic        done;

    ahbl_dma_master_if bus ();

    ahbl_dma_master #(.LEN_W(16)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .len_words (len_words),
        .busy      (busy),
        .done      (done),
        .bus       (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Model state.
    logic [31:0] preload [logic [31:0]];
    logic [31:0] exp_rd [$];
    wr_t         exp_wr [$];
    logic [31:0] rd_log [$];
    wr_t         wr_log [$];
    int          busy_from = 0;
    int          done_at = -1;
    int          done_obs = -1;
    int          waits = 0;
    bit          mon_en = 0;

    // Responder state.
    bit          dp_active = 0;
    bit          dp_write = 0;
    logic [31:0] dp_addr = '0;
    logic [31:0] dp_data = '0;
    int          dp_wait = 0;
    bit          prev_ready = 1;
    logic [31:0] prev_haddr = '0;
    logic [1:0]  prev_htrans = '0;
    logic        prev_hwrite = 1'b0;
    logic [31:0] prev_hwdata = '0;

    always @(posedge HCLK) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (preload.exists(a)) return preload[a];
        return {a[7:0], 8'hD5, ~a[15:0]};
    endfunction

    // Per-cycle compare plus responder.
    always @(negedge HCLK) begin
        logic exp_busy;
        logic ready;
        if (mon_en) begin
            exp_busy = (cyc >= busy_from) && (cyc <= done_at);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("done", {31'b0, done}, {31'b0, (cyc == done_at)});
            check("hsize", {29'b0, bus.HSIZE}, {29'b0, HSIZE_WORD});
            if (!exp_busy) check("htrans_idle", {30'b0, bus.HTRANS}, {30'b0, HTRANS_IDLE});
            if (done) done_obs = cyc;
            if (!prev_ready) begin
                check("hold_haddr", bus.HADDR, prev_haddr);
                check("hold_htrans", {30'b0, bus.HTRANS}, {30'b0, prev_htrans});
                check("hold_hwrite", {31'b0, bus.HWRITE}, {31'b0, prev_hwrite});
                check("hold_hwdata", bus.HWDATA, prev_hwdata);
            end

            if (dp_active && dp_wait > 0) begin
                ready = 1'b0;
                dp_wait--;
            end else begin
                ready = 1'b1;
            end
            bus.HREADY = ready;
            bus.HRDATA = (dp_active && !dp_write) ? mem_rd(dp_addr) : 32'h0BAD_0BAD;

            if (ready) begin
                if (dp_active && dp_write) begin
                    check("hwdata", bus.HWDATA, dp_data);
                    wr_log.push_back('{addr: dp_addr, data: bus.HWDATA});
                end
                dp_active = 0;
                if (bus.HTRANS == HTRANS_NONSEQ) begin
                    dp_active = 1;
                    dp_addr   = bus.HADDR;
                    dp_write  = bus.HWRITE;
                    dp_wait   = waits;
                    if (!bus.HWRITE) begin
                        rd_log.push_back(bus.HADDR);
                        check("rd_pending", {31'b0, (exp_rd.size() > 0)}, 32'd1);
                        if (exp_rd.size() > 0) check("rd_addr", bus.HADDR, exp_rd.pop_front());
                    end else begin
                        check("wr_pending", {31'b0, (exp_wr.size() > 0)}, 32'd1);
                        if (exp_wr.size() > 0) begin
                            wr_t w;
                            w = exp_wr.pop_front();
                            check("wr_addr", bus.HADDR, w.addr);
                            dp_data = w.data;
                        end
                    end
                end
            end
            prev_ready  = ready;
            prev_haddr  = bus.HADDR;
            prev_htrans = bus.HTRANS;
            prev_hwrite = bus.HWRITE;
            prev_hwdata = bus.HWDATA;
        end
    end

    task automatic tick();
        @(negedge HCLK);
        #2;
    endtask

    // Issue a job and record what the copy must look like on the bus.
    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa;
        logic [31:0] da;
        start     = 1'b1;
        src_addr  = s;
        dst_addr  = d;
        len_words = 16'(n);
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < n; i++) begin
            exp_rd.push_back(sa);
            exp_wr.push_back('{addr: da, data: mem_rd(sa)});
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
        busy_from = cyc + 1;
        done_at   = cyc + 1 + n * (4 + 2 * waits);
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int poke, output int c);
        rd_log.delete();
        wr_log.delete();
        done_obs = -1;
        c = cyc;
        do_start(s, d, n);
        for (int k = 1; k <= n * (4 + 2 * waits) + 3; k++) begin
            tick();
            start = (k == poke);
            if (k == poke) begin
                src_addr  = 32'h0000_5000;
                dst_addr  = 32'h0000_6000;
                len_words = 16'd7;
            end
        end
        check("rd_drained", exp_rd.size(), 32'd0);
        check("wr_drained", exp_wr.size(), 32'd0);
    endtask

    initial begin
        int c;
        HRESET     = 1'b1;
        start      = 1'b0;
        src_addr   = '0;
        dst_addr   = '0;
        len_words  = '0;
        bus.HREADY = 1'b1;
        bus.HRDATA = '0;
        tick();
        tick();
        check("rst_htrans", {30'b0, bus.HTRANS}, 32'd0);
        check("rst_haddr", bus.HADDR, 32'd0);
        check("rst_hwrite", {31'b0, bus.HWRITE}, 32'd0);
        check("rst_hwdata", bus.HWDATA, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        HRESET = 1'b0;
        mon_en = 1;
        tick();

        // Single word, zero wait.
        preload[32'h0000_0100] = 32'hCAFE_F00D;
        run_copy(32'h0000_0100, 32'h2000_0000, 1, 0, c);
        check("t1_model_done", 32'(done_at - c), 32'd5);
        check("t1_done_cycle", 32'(done_obs - c), 32'd5);
        check("t1_rd_addr", rd_log[0], 32'h0000_0100);
        check("t1_wr_addr", wr_log[0].addr, 32'h2000_0000);
        check("t1_wr_data", wr_log[0].data, 32'hCAFE_F00D);

        // Three words, with an ignored start mid-copy.
        run_copy(32'h0000_0000, 32'h2000_0010, 3, 3, c);
        check("t2_model_done", 32'(done_at - c), 32'd13);
        check("t2_done_cycle", 32'(done_obs - c), 32'd13);
        check("t2_rd2", rd_log[2], 32'h0000_0008);
        check("t2_wr0", wr_log[0].addr, 32'h2000_0010);
        check("t2_wr2", wr_log[2].addr, 32'h2000_0018);
        check("t2_rd_count", rd_log.size(), 32'd3);

        // Two wait states in every data phase.
        waits = 2;
        run_copy(32'h0000_0040, 32'h3000_0000, 2, 0, c);
        check("t3_model_done", 32'(done_at - c), 32'd17);
        check("t3_done_cycle", 32'(done_obs - c), 32'd17);
        check("t3_wr_count", wr_log.size(), 32'd2);
        waits = 0;

        // Zero-length job.
        run_copy(32'h0000_0700, 32'h0000_0800, 0, 0, c);
        check("t4_model_done", 32'(done_at - c), 32'd1);
        check("t4_done_cycle", 32'(done_obs - c), 32'd1);
        check("t4_no_reads", rd_log.size(), 32'd0);
        check("t4_no_writes", wr_log.size(), 32'd0);

        // Address wrap and alignment.
        run_copy(32'hFFFF_FFFC, 32'h4000_0000, 2, 0, c);
        check("t5_wrap_rd1", rd_log[1], 32'h0000_0000);
        run_copy(32'h0000_0103, 32'h2000_0007, 1, 0, c);
        check("t5_align_rd", rd_log[0], 32'h0000_0100);
        check("t5_align_wr", wr_log[0].addr, 32'h2000_0004);

        // Reset during WR_ADDR of word 2 of 4.
        rd_log.delete();
        wr_log.delete();
        done_obs = -1;
        c = cyc;
        do_start(32'h0000_0200, 32'h2100_0000, 4);
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t6_pre_htrans", {30'b0, bus.HTRANS}, {30'b0, HTRANS_NONSEQ});
        check("t6_pre_haddr", bus.HADDR, 32'h2100_0004);
        HRESET = 1'b1;
        #1;
        check("t6_rst_htrans", {30'b0, bus.HTRANS}, 32'd0);
        check("t6_rst_busy", {31'b0, busy}, 32'd0);
        check("t6_rst_haddr", bus.HADDR, 32'd0);
        exp_rd.delete();
        exp_wr.delete();
        done_at    = -1;
        dp_active  = 0;
        prev_ready = 1;
        tick();
        tick();
        HRESET = 1'b0;
        tick();
        check("t6_no_done", 32'(done_obs), 32'hFFFF_FFFF);
        run_copy(32'h0000_0200, 32'h2100_0000, 2, 0, c);
        check("t6_done_cycle", 32'(done_obs - c), 32'd9);
        check("t6_wr1_data", wr_log[1].data, mem_rd(32'h0000_0204));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ahbl_dma_master.md
AHBL_DMA_MASTER -- requirements
Module: ahbl_dma_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the word-count input.
REQ-002 SHALL have port HCLK  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port HRESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a copy; sampled only in IDLE.
REQ-005 SHALL have port src_addr  input  32  source byte address, sampled with start.
REQ-006 SHALL have port dst_addr  input  32  destination byte address, sampled with start.
REQ-007 SHALL have port len_words  input  LEN_W  number of 32-bit words to copy, sampled with start.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have ports HADDR output 32, HTRANS output 2, HSIZE output 3, HWRITE output 1, HWDATA output 32 (AHB-Lite initiator outputs).
REQ-011 SHALL have ports HREADY input 1, HRDATA input 32 (AHB-Lite initiator inputs from the splitter).

Function
REQ-012 SHALL implement states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, FIN.
REQ-013 IDLE: start=1 with len_words>0 -> latch src/dst (bits [1:0] forced to 0), count=len_words, go RD_ADDR; start=1 with len_words=0 -> FIN, no bus transfer.
REQ-014 RD_ADDR: HADDR=src, HTRANS=2'b10 (NONSEQ), HWRITE=0; on HREADY=1 -> RD_DATA.
REQ-015 RD_DATA: HTRANS=2'b00 (IDLE); on HREADY=1 capture HRDATA into word buffer, go WR_ADDR.
REQ-016 WR_ADDR: HADDR=dst, HTRANS=2'b10, HWRITE=1; on HREADY=1 -> WR_DATA.
REQ-017 WR_DATA: HTRANS=2'b00, HWDATA=word buffer; on HREADY=1 src+=4, dst+=4, count-=1; count reaching 0 -> FIN, else RD_ADDR.
REQ-018 FIN: done=1 for exactly one cycle, then IDLE.
REQ-019 HSIZE SHALL be constant 3'b010 (word); HTRANS SHALL be 2'b00 in IDLE and FIN.
REQ-020 While HREADY=0, HADDR, HTRANS, HWRITE and HWDATA SHALL be held unchanged.
REQ-021 HWDATA SHALL be stable for the whole WR_DATA phase, including wait states.
REQ-022 Address increment SHALL wrap modulo 2^32 (0xFFFF_FFFC+4 -> 0x0000_0000).
REQ-023 start while busy=1 SHALL be ignored; no queuing.
REQ-024 Zero-wait-state throughput SHALL be 4 cycles per word; done SHALL be high in cycle 4N+1 after the start-sampling edge.
REQ-025 busy and done SHALL both be high during FIN.

Reset
REQ-026 HRESET=1 SHALL asynchronously force state IDLE, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, busy=0, done=0, count=0, buffer=0.
REQ-027 Reset mid-transfer SHALL abandon the copy with no done pulse; first post-reset cycle is IDLE.

Structure
REQ-028 A shared package SHALL hold the HTRANS encodings (IDLE, NONSEQ), the HSIZE word encoding and the state enumeration.
REQ-029 The block SHALL be a single module; no sub-module.
REQ-030 All bus outputs SHALL be registered or decoded from registered state only; no combinational path from HRDATA to any output.

Verification
REQ-031 src=0x0000_0100, dst=0x2000_0000, len=1, zero-wait RAM holding 0xCAFE_F00D -> one NONSEQ read at 0x100, one NONSEQ write at 0x2000_0000 with HWDATA=0xCAFE_F00D, done in cycle 5.
REQ-032 len=3, src=0x0, dst=0x2000_0010 -> reads 0x0/0x4/0x8, writes 0x2000_0010/14/18 in order, done in cycle 13, busy low cycle 14.
REQ-033 len=2, responder inserts 2 wait states in every data phase -> control and HWDATA held stable throughout, data copied correctly, done in cycle 17.
REQ-034 len=0 -> no NONSEQ observed, done high in cycle 1 only.
REQ-035 src=0xFFFF_FFFC, len=2 -> second read address 0x0000_0000; src=0x103 -> first read address 0x100.
REQ-036 HRESET asserted during WR_ADDR of word 2 of 4 -> HTRANS=2'b00 immediately, no done, new start after release copies correctly.
